rw_arbiter: RTL and testbench
=============================

# rw_arbiter

Parametrised N-channel arbiter that merges memory requests from the instruction cache, data cache, uncached path and any future requesters onto the single read/write port of the AXI bridge (`axi_rw`). It supersedes the fixed three-port arbiter. It adds a configurable channel count, selectable fixed-priority or round-robin arbitration, transaction tagging by channel ID, and response-ID checking. It serves one transaction at a time: grant, hold until the bridge completes, then return data to the winner.

## Interface
Parameters:
- NUM_CH, 3, number of requester channels (2..8)
- ADDR_W, 64, request address width
- DATA_W, 64, data width; mask width is DATA_W/8
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- ID_W, 4, width of the bridge ID field; must satisfy 2^ID_W ≥ NUM_CH

Ports (per-channel buses are flattened, channel k occupies slice [k*W +: W]):
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- ch_valid_i  in  NUM_CH  request pending, held until the matching ch_done_o
- ch_we_i  in  NUM_CH  0 = read, 1 = write
- ch_addr_i  in  NUM_CH*ADDR_W  request address
- ch_wdata_i  in  NUM_CH*DATA_W  write data
- ch_mask_i  in  NUM_CH*DATA_W/8  byte write mask
- ch_size_i  in  NUM_CH*2  transfer size code
- ch_done_o  out  NUM_CH  one-cycle completion pulse, one-hot
- ch_err_o  out  NUM_CH  asserted together with ch_done_o when the response ID mismatched
- ch_rdata_o  out  DATA_W  read data, valid while ch_done_o is asserted
- rw_valid_o  out  1  bridge request
- rw_ready_i  in  1  bridge completion pulse
- rw_req_o  out  1  0 = read, 1 = write
- rw_addr_o  out  ADDR_W
- data_write_o  out  DATA_W
- w_mask_o  out  DATA_W/8
- rw_size_o  out  2
- rw_id_o  out  ID_W  granted channel index, zero-extended
- rw_id_i  in  ID_W  response ID from the bridge
- data_read_i  in  DATA_W  read data from the bridge

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - If any ch_valid_i is set, pick the winner g and register the winner's request fields and g.
  - Go to BUSY.
- **Fixed-priority mode:** g is the lowest set index.
- **Round-robin mode:** g is the first set index at or after ptr, searching with wrap-around.
  - ptr is updated to (g+1) mod NUM_CH at grant time.
  - ptr is unchanged when nothing is granted.
- **BUSY**
  - rw_valid_o = 1. All rw_* outputs come from registers and are stable.
  - When rw_ready_i = 1:
    - capture data_read_i;
    - set err = (rw_id_i != g);
    - go to RESP.
- **RESP**
  - ch_done_o[g] = 1, ch_err_o[g] = err, ch_rdata_o = captured data.
  - ch_rdata_o is also driven for writes.
  - Return to IDLE.
- Dropping ch_valid_i[g] during BUSY has no effect: the transaction completes and done is still pulsed.
- ch_valid_i of losing channels is ignored until the next IDLE.

## Timing
- Reset values: state IDLE, ptr 0, all outputs 0.
- Reset is asynchronous. Asserting it mid-transaction drops rw_valid_o immediately, and no done pulse is produced.
- Latency:
  - ch_valid_i seen in IDLE at cycle t → rw_valid_o high at t+1.
  - rw_ready_i at cycle u → ch_done_o at u+1.
  - Next grant is at u+2 at the earliest.
- Minimum request-to-done time is 3 cycles (rw_ready_i in the first BUSY cycle).
- rw_valid_o deasserts the cycle after rw_ready_i and never pulses while the FSM is in IDLE.
- rw_ready_i outside BUSY is ignored.

## Structure
- Shared package / defines:
  - FSM state encoding;
  - size-code constants (byte, half, word, double);
  - ID-width default.
- One sub-module, `rr_pick`: combinational find-first-set, taking a request vector and a start pointer and returning a one-hot grant plus its index. It is used with ptr = 0 in fixed mode and with ptr = ptr register in round-robin mode.

## Test plan
- **Single read:** NUM_CH=3, ch_valid_i=001, addr 0x8000_0000, bridge returns 0xDEAD_BEEF_0123_4567 with rw_id_i=0 → rw_valid_o high for the BUSY cycles; ch_done_o=001 for one cycle with that data; ch_err_o=000.
- **Simultaneous requests, round-robin:** ch_valid_i=111 held; instant-ready bridge → grant order 0,1,2,0; rw_id_o matches each grant; exactly one done per transaction.
- **Fixed priority (RR_MODE=0):** ch_valid_i=110 held on every grant → channel 1 wins every time; channel 2 starves.
- **ID mismatch:** grant channel 2, bridge replies rw_id_i=1 → ch_done_o=100, ch_err_o=100.
- **Write pass-through:** ch_we_i[1]=1, mask 0x0F, wdata 0x1122_3344_5566_7788, size 2'b10 → rw_req_o=1 and w_mask_o, data_write_o, rw_size_o match the request; done after rw_ready_i.
- **Reset mid-BUSY and valid drop:**
  - Assert reset during BUSY → rw_valid_o is 0 in the same cycle; after release, state IDLE and ptr 0.
  - Separately, drop ch_valid_i during BUSY → done is still pulsed.

Source files
------------

// File: rtl/rw_arbiter_pkg.sv
// Shared types and constants for the N-channel read/write arbiter.
package rw_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  localparam logic [1:0] SizeByte   = 2'b00;
  localparam logic [1:0] SizeHalf   = 2'b01;
  localparam logic [1:0] SizeWord   = 2'b10;
  localparam logic [1:0] SizeDouble = 2'b11;

  localparam int unsigned IdWDefault = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational find-first-set starting at ptr, wrapping around; returns one-hot grant and index.
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [N-1:0] rot;

  always_comb begin
    int unsigned k;
    // Rotate so that bit 0 is the channel at ptr.
    rot = N'({req, req} >> ptr);
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!any && rot[j]) begin
        any = 1'b1;
        k   = 32'(ptr) + j;
        idx = PW'((k >= N) ? k - N : k);
      end
    end
  end

  assign gnt = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/rw_arbiter.sv
// Merges NUM_CH memory requesters onto one bridge port, one transaction at a time,
// with fixed-priority or round-robin arbitration and response-ID checking.
module rw_arbiter
  import rw_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned ID_W    = IdWDefault
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_valid_i,
  input  logic [NUM_CH-1:0]          ch_we_i,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata_i,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_mask_i,
  input  logic [NUM_CH*2-1:0]        ch_size_i,
  output logic [NUM_CH-1:0]          ch_done_o,
  output logic [NUM_CH-1:0]          ch_err_o,
  output logic [DATA_W-1:0]          ch_rdata_o,
  output logic                       rw_valid_o,
  input  logic                       rw_ready_i,
  output logic                       rw_req_o,
  output logic [ADDR_W-1:0]          rw_addr_o,
  output logic [DATA_W-1:0]          data_write_o,
  output logic [DATA_W/8-1:0]        w_mask_o,
  output logic [1:0]                 rw_size_o,
  output logic [ID_W-1:0]            rw_id_o,
  input  logic [ID_W-1:0]            rw_id_i,
  input  logic [DATA_W-1:0]          data_read_i
);

  localparam int unsigned PW = $clog2(NUM_CH);
  localparam int unsigned MW = DATA_W / 8;

  state_e            state_q;
  logic [PW-1:0]     g_q, ptr_q;
  logic [NUM_CH-1:0] gnt_q;

  logic [PW-1:0]     pick_ptr, pick_idx;
  logic [NUM_CH-1:0] pick_gnt;
  logic              pick_any;

  // Fixed-priority mode always searches from channel 0.
  assign pick_ptr = (RR_MODE != 0) ? ptr_q : '0;

  rr_pick #(
    .N  (NUM_CH),
    .PW (PW)
  ) u_pick (
    .req (ch_valid_i),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      g_q          <= '0;
      gnt_q        <= '0;
      ptr_q        <= '0;
      ch_done_o    <= '0;
      ch_err_o     <= '0;
      ch_rdata_o   <= '0;
      rw_valid_o   <= 1'b0;
      rw_req_o     <= 1'b0;
      rw_addr_o    <= '0;
      data_write_o <= '0;
      w_mask_o     <= '0;
      rw_size_o    <= '0;
      rw_id_o      <= '0;
    end else begin
      ch_done_o <= '0;
      ch_err_o  <= '0;
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            g_q          <= pick_idx;
            gnt_q        <= pick_gnt;
            rw_id_o      <= ID_W'(pick_idx);
            rw_req_o     <= ch_we_i[pick_idx];
            rw_addr_o    <= ch_addr_i[pick_idx*ADDR_W +: ADDR_W];
            data_write_o <= ch_wdata_i[pick_idx*DATA_W +: DATA_W];
            w_mask_o     <= ch_mask_i[pick_idx*MW +: MW];
            rw_size_o    <= ch_size_i[pick_idx*2 +: 2];
            rw_valid_o   <= 1'b1;
            if (RR_MODE != 0) begin
              ptr_q <= (pick_idx == PW'(NUM_CH - 1)) ? '0 : pick_idx + PW'(1);
            end
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (rw_ready_i) begin
            rw_valid_o <= 1'b0;
            ch_rdata_o <= data_read_i;
            ch_done_o  <= gnt_q;
            ch_err_o   <= (rw_id_i != ID_W'(g_q)) ? gnt_q : '0;
            state_q    <= StResp;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rw_arbiter.sv
// Bench for rw_arbiter: a fixed-priority and a round-robin instance share the requester
// stimulus; a transaction-level model is compared against both every cycle.
module tb_rw_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 8;
  localparam int unsigned IW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]    ch_valid = '0;
  logic [N-1:0]    ch_we    = '0;
  logic [N*AW-1:0] ch_addr  = '0;
  logic [N*DW-1:0] ch_wdata = '0;
  logic [N*MW-1:0] ch_mask  = '0;
  logic [N*2-1:0]  ch_size  = '0;
  logic [DW-1:0]   brg_rdata = '0;

  // Index 0: fixed priority, index 1: round-robin.
  logic          rdy   [2] = '{1'b0, 1'b0};
  logic [IW-1:0] id_in [2] = '{'0, '0};
  logic [N-1:0]  done_o [2];
  logic [N-1:0]  err_o  [2];
  logic [DW-1:0] rdata_o[2];
  logic          valid_o[2];
  logic          req_o  [2];
  logic [AW-1:0] addr_o [2];
  logic [DW-1:0] wdata_o[2];
  logic [MW-1:0] mask_o [2];
  logic [1:0]    size_o [2];
  logic [IW-1:0] id_o   [2];

  rw_arbiter #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .ID_W(IW)
  ) dut_fx (
    .clock(clock), .reset(reset), .ch_valid_i(ch_valid), .ch_we_i(ch_we),
    .ch_addr_i(ch_addr), .ch_wdata_i(ch_wdata), .ch_mask_i(ch_mask), .ch_size_i(ch_size),
    .ch_done_o(done_o[0]), .ch_err_o(err_o[0]), .ch_rdata_o(rdata_o[0]),
    .rw_valid_o(valid_o[0]), .rw_ready_i(rdy[0]), .rw_req_o(req_o[0]), .rw_addr_o(addr_o[0]),
    .data_write_o(wdata_o[0]), .w_mask_o(mask_o[0]), .rw_size_o(size_o[0]), .rw_id_o(id_o[0]),
    .rw_id_i(id_in[0]), .data_read_i(brg_rdata)
  );

  rw_arbiter #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .ID_W(IW)
  ) dut_rr (
    .clock(clock), .reset(reset), .ch_valid_i(ch_valid), .ch_we_i(ch_we),
    .ch_addr_i(ch_addr), .ch_wdata_i(ch_wdata), .ch_mask_i(ch_mask), .ch_size_i(ch_size),
    .ch_done_o(done_o[1]), .ch_err_o(err_o[1]), .ch_rdata_o(rdata_o[1]),
    .rw_valid_o(valid_o[1]), .rw_ready_i(rdy[1]), .rw_req_o(req_o[1]), .rw_addr_o(addr_o[1]),
    .data_write_o(wdata_o[1]), .w_mask_o(mask_o[1]), .rw_size_o(size_o[1]), .rw_id_o(id_o[1]),
    .rw_id_i(id_in[1]), .data_read_i(brg_rdata)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner by the arbitration rules: first requester at/after start, wrapping.
  function automatic int pick(input int m, input logic [N-1:0] req, input int p);
    int k;
    for (int i = 0; i < N; i++) begin
      k = ((m == 1) ? p + i : i) % N;
      if (((req >> k) & N'(1)) != '0) return k;
    end
    return -1;
  endfunction

  // Transaction-level model: an open transaction is either waiting on the bridge or answered.
  bit            m_live [2];
  bit            m_ans  [2];
  bit            m_err  [2];
  int            m_ch   [2];
  int            m_ptr  [2];
  logic          m_we   [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata[2];
  logic [MW-1:0] m_mask [2];
  logic [1:0]    m_size [2];
  logic [DW-1:0] m_data [2];
  int            pk     [2];

  assign pk[0] = pick(0, ch_valid, m_ptr[0]);
  assign pk[1] = pick(1, ch_valid, m_ptr[1]);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        m_live[m] <= 1'b0;
        m_ans[m]  <= 1'b0;
        m_err[m]  <= 1'b0;
        m_ptr[m]  <= 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (m_live[m] && m_ans[m]) begin
          m_live[m] <= 1'b0;
        end else if (m_live[m]) begin
          if (rdy[m]) begin
            m_ans[m]  <= 1'b1;
            m_data[m] <= brg_rdata;
            m_err[m]  <= (int'(id_in[m]) != m_ch[m]);
          end
        end else if (pk[m] >= 0) begin
          m_live[m]  <= 1'b1;
          m_ans[m]   <= 1'b0;
          m_ch[m]    <= pk[m];
          m_we[m]    <= ch_we[pk[m] +: 1];
          m_addr[m]  <= ch_addr[pk[m]*AW +: AW];
          m_wdata[m] <= ch_wdata[pk[m]*DW +: DW];
          m_mask[m]  <= ch_mask[pk[m]*MW +: MW];
          m_size[m]  <= ch_size[pk[m]*2 +: 2];
          if (m == 1) m_ptr[m] <= (pk[m] + 1) % N;
        end
      end
    end
  end

  // Bridge behaviour: answer after lat extra BUSY cycles, optionally with a forced ID.
  int            lat      = 0;
  bit            force_en = 1'b0;
  logic [IW-1:0] force_id = '0;
  bit            stray    = 1'b0;
  int            cnt [2]  = '{0, 0};

  always @(negedge clock) begin
    for (int m = 0; m < 2; m++) begin
      logic [N-1:0] exp_d;
      exp_d = (m_live[m] && m_ans[m]) ? (N'(1) << m_ch[m]) : '0;
      check($sformatf("dut%0d rw_valid", m), 64'(valid_o[m]), 64'(m_live[m] && !m_ans[m]));
      check($sformatf("dut%0d ch_done", m), 64'(done_o[m]), 64'(exp_d));
      check($sformatf("dut%0d ch_err", m), 64'(err_o[m]), 64'(m_err[m] ? exp_d : '0));
      if (exp_d != '0) check($sformatf("dut%0d ch_rdata", m), rdata_o[m], m_data[m]);
      if (m_live[m] && !m_ans[m]) begin
        check($sformatf("dut%0d rw_id", m), 64'(id_o[m]), 64'(m_ch[m]));
        check($sformatf("dut%0d rw_req", m), 64'(req_o[m]), 64'(m_we[m]));
        check($sformatf("dut%0d rw_addr", m), addr_o[m], m_addr[m]);
        check($sformatf("dut%0d data_write", m), wdata_o[m], m_wdata[m]);
        check($sformatf("dut%0d w_mask", m), 64'(mask_o[m]), 64'(m_mask[m]));
        check($sformatf("dut%0d rw_size", m), 64'(size_o[m]), 64'(m_size[m]));
      end
      id_in[m] = force_en ? force_id : id_o[m];
      if (valid_o[m] && cnt[m] >= lat) begin
        rdy[m] = 1'b1;
        cnt[m] = 0;
      end else begin
        rdy[m] = stray;
        cnt[m] = valid_o[m] ? cnt[m] + 1 : 0;
      end
    end
  end

  task automatic wait_valid(input int m);
    int n = 0;
    while (valid_o[m] !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("wait rw_valid timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_done(input int m);
    int n = 0;
    while (done_o[m] === '0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("wait ch_done timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    ch_valid = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  int exp_rr_a[4] = '{0, 1, 2, 0};
  int exp_rr_b[4] = '{1, 2, 1, 2};

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      check("reset rw_valid", 64'(valid_o[m]), 64'(0));
      check("reset ch_done", 64'(done_o[m]), 64'(0));
      check("reset rw_addr", addr_o[m], 64'(0));
      check("reset rw_id", 64'(id_o[m]), 64'(0));
    end

    // Single read on channel 0.
    ch_addr[0 +: AW] = 64'h8000_0000;
    brg_rdata        = 64'hDEAD_BEEF_0123_4567;
    lat              = 1;
    @(negedge clock);
    ch_valid = 3'b001;
    @(negedge clock);
    check("read rw_valid t+1", 64'(valid_o[1]), 64'(1));
    check("read rw_addr", addr_o[1], 64'h8000_0000);
    wait_done(1);
    check("read done", 64'(done_o[1]), 64'(3'b001));
    check("read data", rdata_o[1], 64'hDEAD_BEEF_0123_4567);
    check("read err", 64'(err_o[1]), 64'(0));
    ch_valid = '0;
    @(negedge clock);
    check("read done one cycle", 64'(done_o[1]), 64'(0));

    // All three requesting, instant bridge.
    do_reset();
    lat      = 0;
    ch_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_valid(1);
      check("rr grant 111", 64'(id_o[1]), 64'(exp_rr_a[k]));
      check("fx grant 111", 64'(id_o[0]), 64'(0));
      wait_done(1);
      check("rr done 111", 64'(done_o[1]), 64'(3'b001 << exp_rr_a[k]));
    end

    // Channels 1 and 2 requesting: fixed priority starves channel 2.
    do_reset();
    ch_valid = 3'b110;
    for (int k = 0; k < 4; k++) begin
      wait_valid(1);
      check("rr grant 110", 64'(id_o[1]), 64'(exp_rr_b[k]));
      check("fx grant 110", 64'(id_o[0]), 64'(1));
      wait_done(1);
      check("fx done 110", 64'(done_o[0]), 64'(3'b010));
    end

    // Bridge answers channel 2 with ID 1.
    do_reset();
    force_en = 1'b1;
    force_id = 4'd1;
    ch_valid = 3'b100;
    wait_done(1);
    check("id mismatch done", 64'(done_o[1]), 64'(3'b100));
    check("id mismatch err", 64'(err_o[1]), 64'(3'b100));
    check("id mismatch err fx", 64'(err_o[0]), 64'(3'b100));
    ch_valid = '0;
    force_en = 1'b0;

    // Write on channel 1.
    ch_we               = 3'b010;
    ch_addr[AW +: AW]   = 64'h0000_1000;
    ch_wdata[DW +: DW]  = 64'h1122_3344_5566_7788;
    ch_mask[MW +: MW]   = 8'h0F;
    ch_size[2 +: 2]     = 2'b10;
    brg_rdata           = 64'h0BAD_F00D_0000_0001;
    lat                 = 2;
    @(negedge clock);
    ch_valid = 3'b010;
    wait_valid(1);
    check("write rw_req", 64'(req_o[1]), 64'(1));
    check("write w_mask", 64'(mask_o[1]), 64'h0F);
    check("write data", wdata_o[1], 64'h1122_3344_5566_7788);
    check("write size", 64'(size_o[1]), 64'(2'b10));
    wait_done(1);
    check("write done", 64'(done_o[1]), 64'(3'b010));
    ch_valid = '0;
    ch_we    = '0;

    // Stray ready while idle.
    repeat (2) @(negedge clock);
    stray = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("stray ready valid", 64'(valid_o[1]), 64'(0));
      check("stray ready done", 64'(done_o[1]), 64'(0));
    end
    stray = 1'b0;
    @(negedge clock);

    // Requester drops valid during BUSY.
    lat      = 3;
    ch_valid = 3'b001;
    wait_valid(1);
    ch_valid = '0;
    wait_done(1);
    check("valid drop done", 64'(done_o[1]), 64'(3'b001));

    // Reset in the middle of BUSY.
    repeat (2) @(negedge clock);
    lat      = 6;
    ch_valid = 3'b001;
    wait_valid(1);
    #1 reset = 1'b1;
    #1;
    check("reset mid busy rr", 64'(valid_o[1]), 64'(0));
    check("reset mid busy fx", 64'(valid_o[0]), 64'(0));
    ch_valid = '0;
    @(negedge clock);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clock);
      check("no done after reset", 64'(done_o[1]), 64'(0));
    end
    lat      = 0;
    ch_valid = 3'b111;
    wait_valid(1);
    check("ptr cleared by reset", 64'(id_o[1]), 64'(0));
    wait_done(1);
    ch_valid = '0;

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran too long, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
